// File: rtl/gift_iter_enc.sv
// Round-iterative GIFT-128 encryptor: one round per clock, ROUNDS+1 cycles per block.
// Optional macro GIFT_ENC_LASTKEY_EN adds outLastKey (final working key, for the decryptor).
module gift_iter_enc #(
  parameter int ROUNDS = 40
) (
  input  logic         inClk,
  input  logic         inRstN,
  input  logic         inKeyWr,
  input  logic [127:0] inKeyData,
  input  logic         inDataWr,
  input  logic [127:0] inDataData,
  output logic [127:0] outData,
  output logic         outValidData,
  output logic         outBusy
`ifdef GIFT_ENC_LASTKEY_EN
  ,
  output logic [127:0] outLastKey
`endif
);

  localparam int CW = $clog2(ROUNDS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t           state_reg, state_next;
  logic [127:0]   data_reg;
  logic [127:0]   key_reg;
  logic [127:0]   wkey_reg;
  logic [127:0]   wkey_next;
  logic [CW-1:0]  cnt_reg;
  logic [5:0]     lfsr_reg;
  logic [5:0]     lfsr_next;
  logic [127:0]   out_data_reg;
  logic           out_valid_reg;
  logic [127:0]   sub;
  logic [127:0]   perm;
  logic [127:0]   ark;
  logic [127:0]   round_out;
  logic           last_round;
`ifdef GIFT_ENC_LASTKEY_EN
  logic [127:0]   last_key_reg;
`endif

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'h1;  4'h1: sbox = 4'ha;  4'h2: sbox = 4'h4;  4'h3: sbox = 4'hc;
      4'h4: sbox = 4'h6;  4'h5: sbox = 4'hf;  4'h6: sbox = 4'h3;  4'h7: sbox = 4'h9;
      4'h8: sbox = 4'h2;  4'h9: sbox = 4'hd;  4'ha: sbox = 4'hb;  4'hb: sbox = 4'h7;
      4'hc: sbox = 4'h5;  4'hd: sbox = 4'h0;  4'he: sbox = 4'h8;  default: sbox = 4'he;
    endcase
  endfunction

  // Round datapath: SubCells -> PermBits -> AddRoundKey; the permutation is pure wiring.
  for (genvar gi = 0; gi < 32; gi++) begin : g_sbox
    assign sub[4*gi +: 4] = sbox(data_reg[4*gi +: 4]);
  end

  for (genvar gi = 0; gi < 128; gi++) begin : g_perm
    localparam int P = 4 * (gi / 16) + 32 * ((3 * ((gi % 16) / 4) + (gi % 4)) % 4) + (gi % 4);
    assign perm[P] = sub[gi];
  end

  for (genvar gi = 0; gi < 32; gi++) begin : g_ark
    assign ark[4*gi+3] = perm[4*gi+3];
    assign ark[4*gi+2] = perm[4*gi+2] ^ wkey_reg[64+gi];
    assign ark[4*gi+1] = perm[4*gi+1] ^ wkey_reg[gi];
    assign ark[4*gi]   = perm[4*gi];
  end

  // The LFSR advances before use, so the first round sees 6'h01.
  assign lfsr_next = {lfsr_reg[4:0], lfsr_reg[5] ^ lfsr_reg[4] ^ 1'b1};

  always_comb begin
    round_out      = ark;
    round_out[127] = ark[127] ^ 1'b1;
    round_out[23]  = ark[23] ^ lfsr_next[5];
    round_out[19]  = ark[19] ^ lfsr_next[4];
    round_out[15]  = ark[15] ^ lfsr_next[3];
    round_out[11]  = ark[11] ^ lfsr_next[2];
    round_out[7]   = ark[7]  ^ lfsr_next[1];
    round_out[3]   = ark[3]  ^ lfsr_next[0];
  end

  // k7..k0 <= k1>>>2, k0>>>12, k7..k2 (16-bit word rotations).
  assign wkey_next = {wkey_reg[17:16], wkey_reg[31:18],
                      wkey_reg[11:0],  wkey_reg[15:12],
                      wkey_reg[127:32]};

  assign last_round = (state_reg == RUN) && (cnt_reg == CW'(ROUNDS - 1));

  always_ff @(posedge inClk) begin
    if (!inRstN) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (inDataWr) state_next = RUN;
      RUN:     if (last_round) state_next = DONE;
      DONE:    state_next = inDataWr ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge inClk) begin
    if (!inRstN) begin
      data_reg      <= '0;
      key_reg       <= '0;
      wkey_reg      <= '0;
      cnt_reg       <= '0;
      lfsr_reg      <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
`ifdef GIFT_ENC_LASTKEY_EN
      last_key_reg  <= '0;
`endif
    end else begin
      out_valid_reg <= 1'b0;
      if (state_reg != RUN) begin
        if (inKeyWr) key_reg <= inKeyData;
        if (inDataWr) begin
          data_reg <= inDataData;
          wkey_reg <= inKeyWr ? inKeyData : key_reg;
          cnt_reg  <= '0;
          lfsr_reg <= '0;
        end
      end else begin
        data_reg <= round_out;
        wkey_reg <= wkey_next;
        lfsr_reg <= lfsr_next;
        if (cnt_reg != CW'(ROUNDS)) cnt_reg <= cnt_reg + 1'b1;
        if (last_round) begin
          out_data_reg  <= round_out;
          out_valid_reg <= 1'b1;
`ifdef GIFT_ENC_LASTKEY_EN
          last_key_reg  <= wkey_next;
`endif
        end
      end
    end
  end

  assign outData      = out_data_reg;
  assign outValidData = out_valid_reg;
  assign outBusy      = (state_reg == RUN);
`ifdef GIFT_ENC_LASTKEY_EN
  assign outLastKey   = last_key_reg;
`endif

endmodule

// File: tb/tb_gift_iter_enc.sv
// Directed-vector bench for gift_iter_enc using published GIFT-128 test vectors.
module tb_gift_iter_enc;

  localparam logic [127:0] KF  = 128'hfedcba9876543210fedcba9876543210;
  localparam logic [127:0] CT0 = 128'hcd0bd738388ad3f668b15a36ceb6ff92;
  localparam logic [127:0] CTF = 128'h8422241a6dbf5a9346af468409ee0152;
  localparam logic [127:0] LKF = 128'hcfed98ba47651032cfed98ba47651032;
  localparam int M_TOGETHER = 0, M_DATA = 1, M_SPLIT = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_wr = 1'b0;
  logic [127:0] key_data = '0;
  logic         data_wr = 1'b0;
  logic [127:0] data_data = '0;
  logic [127:0] data_out;
  logic         valid;
  logic         busy;
`ifdef GIFT_ENC_LASTKEY_EN
  logic [127:0] last_key;
`endif

  int checks = 0;
  int errors = 0;

  gift_iter_enc dut (
    .inClk(clk), .inRstN(rst_n),
    .inKeyWr(key_wr), .inKeyData(key_data),
    .inDataWr(data_wr), .inDataData(data_data),
    .outData(data_out), .outValidData(valid), .outBusy(busy)
`ifdef GIFT_ENC_LASTKEY_EN
    , .outLastKey(last_key)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int           mode;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    logic [127:0] lk;
  } vec_t;

  task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_block(input int mode, input logic [127:0] key, input logic [127:0] pt, input string name);
    @(negedge clk);
    case (mode)
      M_TOGETHER: begin key_wr = 1; data_wr = 1; key_data = key; data_data = pt; end
      M_DATA:     begin key_wr = 0; data_wr = 1; key_data = key; data_data = pt; end
      default: begin
        key_wr = 1; key_data = key; data_data = ~pt;
        @(negedge clk);
        key_wr = 0;
        check(busy == 1'b0, {name, " key-only write stays idle"}, 128'(busy), 128'(0));
        repeat (2) @(negedge clk);
        data_wr = 1; data_data = pt;
      end
    endcase
    @(negedge clk);
    key_wr = 0;
    data_wr = 0;
  endtask

  // Called at the first negedge after the capture edge; returns at the negedge after the pulse.
  task automatic wait_result(input string name, input logic [127:0] exp_ct, input logic [127:0] exp_lk,
                             input int inj, input bit chain);
    int lat = -1;
    int busy_bad = 0;
    for (int c = 0; c <= 60; c++) begin
      if (c > 0) @(negedge clk);
      if (inj != 0 && c == inj) begin
        key_wr = 1; data_wr = 1; key_data = KF; data_data = KF;
      end
      if (inj != 0 && c == inj + 1) begin
        key_wr = 0; data_wr = 0;
      end
      if (valid) begin
        lat = c;
        break;
      end
      if (!busy) busy_bad++;
    end
    $display("block %s: ct=%h latency=%0d", name, data_out, lat);
    check(lat == 40, {name, " latency"}, 128'(lat), 128'(40));
    check(busy_bad == 0, {name, " busy during rounds"}, 128'(busy_bad), 128'(0));
    check(data_out === exp_ct, {name, " ciphertext"}, data_out, exp_ct);
    check(busy == 1'b0, {name, " busy at pulse"}, 128'(busy), 128'(0));
`ifdef GIFT_ENC_LASTKEY_EN
    check(last_key === exp_lk, {name, " last key"}, last_key, exp_lk);
`else
    if (exp_lk != exp_lk) $display("unreachable");
`endif
    if (chain) begin
      key_wr = 0; data_wr = 1; data_data = '0;
    end
    @(negedge clk);
    data_wr = 0;
    check(valid == 1'b0, {name, " single-cycle pulse"}, 128'(valid), 128'(0));
  endtask

  initial begin
    vec_t vecs[5];
    int pulses;
    vecs[0] = '{M_TOGETHER, '0, '0, CT0, '0};
    vecs[1] = '{M_TOGETHER, KF, KF, CTF, LKF};
    vecs[2] = '{M_DATA,     '0, KF, CTF, LKF};  // stored key KF must be used, not key_data
    vecs[3] = '{M_SPLIT,    '0, '0, CT0, '0};
    vecs[4] = '{M_SPLIT,    KF, KF, CTF, LKF};

    repeat (3) @(negedge clk);
    check(data_out === '0, "reset outData", data_out, '0);
    check(valid == 1'b0, "reset valid", 128'(valid), 128'(0));
    check(busy == 1'b0, "reset busy", 128'(busy), 128'(0));
    rst_n = 1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      start_block(vecs[i].mode, vecs[i].key, vecs[i].pt, nm);
      wait_result(nm, vecs[i].ct, vecs[i].lk, 0, 1'b0);
      repeat (2) @(negedge clk);
    end

    // Writes while busy are dropped, including the key; a write in the pulse cycle starts the next block.
    start_block(M_TOGETHER, '0, '0, "busy_drop");
    wait_result("busy_drop", CT0, '0, 10, 1'b1);
    wait_result("pulse_cycle_write", CT0, '0, 0, 1'b0);

    // Reset mid-block aborts it with no pulse.
    start_block(M_TOGETHER, KF, KF, "abort");
    repeat (19) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    check(data_out === '0, "abort reset outData", data_out, '0);
    check(valid == 1'b0, "abort reset valid", 128'(valid), 128'(0));
    check(busy == 1'b0, "abort reset busy", 128'(busy), 128'(0));
    rst_n = 1;
    pulses = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (valid) pulses++;
    end
    $display("block abort: pulses after reset=%0d", pulses);
    check(pulses == 0, "abort no pulse", 128'(pulses), 128'(0));
    check(data_out === '0, "abort outData held", data_out, '0);

    start_block(M_TOGETHER, '0, '0, "post_reset");
    wait_result("post_reset", CT0, '0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
